// File: rtl/mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_scheduler
// Purpose  : Round-robin scheduler granting byte-capped memory slots to four
//            write ports and four read ports, with per-slot timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_scheduler #(
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  port_mask,
  input  logic [87:0] pend_counts,
  output logic        grant_valid,
  output logic [2:0]  grant_port,
  output logic        grant_dir,
  output logic [10:0] grant_len,
  input  logic        grant_ready,
  input  logic        xfer_done,
  output logic        abort,
  output logic        timeout_err,
  input  logic        err_clear,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;
  localparam logic [1:0] S_BUSY  = 2'd3;

  localparam logic [10:0] C_MAX_BURST    = 11'(MAX_BURST);
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [2:0]  r_rr_ptr;
  logic [15:0] r_timer;
  logic [2:0]  r_grant_port;
  logic        r_grant_dir;
  logic [10:0] r_grant_len;
  logic        r_abort;
  logic        r_timeout_err;

  logic [10:0] w_pend [8];
  logic        w_found;
  logic [2:0]  w_sel;
  logic        w_timeout;
  logic        w_slot_end;
  logic        w_latch;

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign w_pend[g] = pend_counts[11*g +: 11];
  end

  // Walk from the farthest offset back to rr_ptr so the nearest eligible port wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (port_mask[r_rr_ptr + 3'(i)] && (w_pend[r_rr_ptr + 3'(i)] != 11'd0)) begin
        w_found = 1'b1;
        w_sel   = r_rr_ptr + 3'(i);
      end
    end
  end

  // A coinciding xfer_done always takes precedence over the timeout.
  assign w_timeout  = (r_state == S_BUSY) && (r_timer == C_TIMEOUT_LAST) && !xfer_done;
  assign w_slot_end = (r_state == S_BUSY) && (xfer_done || w_timeout);
  assign w_latch    = (r_state == S_SCAN) && enable && w_found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next_state = S_SCAN;
      S_SCAN: begin
        if (!enable)      w_next_state = S_IDLE;
        else if (w_found) w_next_state = S_OFFER;
      end
      S_OFFER: begin
        if (grant_ready)  w_next_state = S_BUSY;
        else if (!enable) w_next_state = S_IDLE;
      end
      S_BUSY:  if (w_slot_end) w_next_state = enable ? S_SCAN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    grant_valid = (r_state == S_OFFER);
    busy        = (r_state == S_OFFER) || (r_state == S_BUSY);
    grant_port  = r_grant_port;
    grant_dir   = r_grant_dir;
    grant_len   = r_grant_len;
    abort       = r_abort;
    timeout_err = r_timeout_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= 3'd0;
      r_timer       <= 16'd0;
      r_grant_port  <= 3'd0;
      r_grant_dir   <= 1'b0;
      r_grant_len   <= 11'd0;
      r_abort       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_grant_port <= w_sel;
        r_grant_dir  <= ~w_sel[2];
        r_grant_len  <= (w_pend[w_sel] > C_MAX_BURST) ? C_MAX_BURST : w_pend[w_sel];
      end
      if (w_slot_end) begin
        r_rr_ptr <= r_grant_port + 3'd1;
      end
      if ((r_state == S_OFFER) && grant_ready) begin
        r_timer <= 16'd0;
      end else if ((r_state == S_BUSY) && (r_timer != 16'hFFFF)) begin
        r_timer <= r_timer + 16'd1;
      end
      r_abort <= w_timeout;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clear) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_scheduler
// Purpose  : Directed self-checking bench for mem_port_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  port_mask;
  logic [87:0] pend_counts;
  logic        grant_valid;
  logic [2:0]  grant_port;
  logic        grant_dir;
  logic [10:0] grant_len;
  logic        grant_ready;
  logic        xfer_done;
  logic        abort;
  logic        timeout_err;
  logic        err_clear;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_port_scheduler #(.MAX_BURST(64), .TIMEOUT(16)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .port_mask   (port_mask),
    .pend_counts (pend_counts),
    .grant_valid (grant_valid),
    .grant_port  (grant_port),
    .grant_dir   (grant_dir),
    .grant_len   (grant_len),
    .grant_ready (grant_ready),
    .xfer_done   (xfer_done),
    .abort       (abort),
    .timeout_err (timeout_err),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pend(input int p, input int v);
    pend_counts[11*p +: 11] = 11'(v);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_valid && n < 20) begin
      step();
      n++;
    end
    if (!grant_valid) check("grant_wait_expired", 32'(grant_valid), 32'd1);
  endtask

  // Accept immediately, drop ready, and return done three cycles after acceptance.
  task automatic serve(input int p, input int len);
    wait_grant();
    check("grant_port", 32'(grant_port), 32'(p));
    check("grant_dir",  32'(grant_dir),  (p < 4) ? 32'd1 : 32'd0);
    check("grant_len",  32'(grant_len),  32'(len));
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    check("valid_drop", 32'(grant_valid), 32'd0);
    check("busy_slot",  32'(busy),        32'd1);
    step();
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    port_mask   = 8'hFF;
    pend_counts = '0;
    grant_ready = 1'b0;
    xfer_done   = 1'b0;
    err_clear   = 1'b0;
    #3;
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_len",   32'(grant_len),   32'd0);
    check("rst_err",   32'(timeout_err), 32'd0);
    step();
    step();
    reset = 1'b1;

    // Fairness: every port pending 10 bytes.
    for (int p = 0; p < 8; p++) set_pend(p, 10);
    enable = 1'b1;
    for (int k = 0; k < 9; k++) serve(k % 8, 10);

    // Burst cap on a read port, then a short write port.
    pend_counts = '0;
    set_pend(5, 2000);
    serve(5, 64);
    pend_counts = '0;
    set_pend(2, 7);
    serve(2, 7);

    // Service port 6 so rr_ptr lands on 7, then only port 0 is unmasked.
    pend_counts = '0;
    set_pend(6, 5);
    serve(6, 5);
    pend_counts = '0;
    port_mask   = 8'b0000_0001;
    set_pend(0, 1);
    set_pend(7, 9);
    serve(0, 1);

    // Timeout: accepted slot never completes.
    port_mask   = 8'hFF;
    pend_counts = '0;
    set_pend(3, 20);
    set_pend(4, 6);
    wait_grant();
    check("to_port", 32'(grant_port), 32'd3);
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_abort_early", 32'(abort), 32'd0);
    step();
    check("to_abort",      32'(abort),       32'd1);
    check("to_err",        32'(timeout_err), 32'd1);
    check("to_busy_clear", 32'(busy),        32'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("to_abort_pulse", 32'(abort),       32'd0);
    check("err_cleared",    32'(timeout_err), 32'd0);
    pend_counts = '0;
    set_pend(4, 6);
    serve(4, 6);

    // Done coinciding with the timeout cycle suppresses abort.
    pend_counts = '0;
    set_pend(5, 30);
    wait_grant();
    check("dc_port", 32'(grant_port), 32'd5);
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    check("dc_abort", 32'(abort),       32'd0);
    check("dc_err",   32'(timeout_err), 32'd0);
    check("dc_busy",  32'(busy),        32'd0);

    // Withdraw during OFFER, then the same port is re-offered.
    pend_counts = '0;
    set_pend(6, 12);
    set_pend(1, 3);
    wait_grant();
    check("wd_port", 32'(grant_port), 32'd6);
    enable = 1'b0;
    step();
    check("wd_valid", 32'(grant_valid), 32'd0);
    check("wd_busy",  32'(busy),        32'd0);
    step();
    step();
    enable = 1'b1;
    serve(6, 12);

    // Asynchronous reset in the middle of a slot.
    pend_counts = '0;
    set_pend(7, 3);
    set_pend(2, 4);
    wait_grant();
    check("ar_port", 32'(grant_port), 32'd7);
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_busy",  32'(busy),        32'd0);
    check("ar_valid", 32'(grant_valid), 32'd0);
    check("ar_port0", 32'(grant_port),  32'd0);
    check("ar_len",   32'(grant_len),   32'd0);
    check("ar_abort", 32'(abort),       32'd0);
    step();
    reset = 1'b1;
    serve(2, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 Parameter MAX_BURST, default 64: maximum bytes granted per service slot; legal range 1..2047.
REQ-002 Parameter TIMEOUT, default 4096: clk cycles allowed between grant acceptance and xfer_done; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 enable  input  1  1 = scheduling permitted.
REQ-006 port_mask  input  8  per-port service enable; bit p enables port p.
REQ-007 pend_counts  input  88  pending byte count per port, 11 bits each; port p occupies bits [11p+10:11p]; ports 0-3 are write ports (FIFO to RAM), ports 4-7 are read ports (RAM to FIFO).
REQ-008 grant_valid  output  1  a grant is offered.
REQ-009 grant_port  output  3  granted port index.
REQ-010 grant_dir  output  1  1 = write (port 0-3), 0 = read (port 4-7).
REQ-011 grant_len  output  11  bytes to transfer in this slot.
REQ-012 grant_ready  input  1  memory engine accepts the offered grant.
REQ-013 xfer_done  input  1  single-cycle pulse: engine finished the current slot.
REQ-014 abort  output  1  single-cycle pulse: the current slot was abandoned on timeout.
REQ-015 timeout_err  output  1  sticky flag: at least one timeout has occurred.
REQ-016 err_clear  input  1  clears timeout_err.
REQ-017 busy  output  1  1 while state is OFFER or BUSY.

Function
REQ-018 The state machine SHALL have four states: IDLE, SCAN, OFFER and BUSY.
REQ-019 IDLE: when enable=1, go to SCAN on the next cycle.
REQ-020 SCAN: search ports starting at rr_ptr, in order rr_ptr, rr_ptr+1, ... (mod 8); select the first port p with port_mask[p]=1 and pend_counts[p]!=0. The search is combinational and completes in one cycle.
REQ-021 SCAN with a port found: latch grant_port=p, grant_dir=(p<4), grant_len=min(pend_counts[p],MAX_BURST); go to OFFER, with grant_valid=1 on the next cycle.
REQ-022 SCAN with no eligible port: remain in SCAN, with outputs unchanged and grant_valid=0.
REQ-023 SCAN with enable=0: go to IDLE.
REQ-024 OFFER: hold grant_valid=1 and hold grant_port, grant_dir and grant_len constant until grant_ready=1, regardless of pend_counts changes.
REQ-025 OFFER with grant_ready=1: go to BUSY next cycle, drop grant_valid, and load timer=0.
REQ-026 OFFER with enable=0 and grant_ready=0: withdraw the grant (grant_valid=0 next cycle), go to IDLE, and leave rr_ptr unchanged.
REQ-027 OFFER with enable=0 and grant_ready=1 in the same cycle: acceptance wins; go to BUSY.
REQ-028 BUSY: increment timer each cycle; timer is 16 bits and saturates.
REQ-029 BUSY with xfer_done=1: set rr_ptr=grant_port+1 (mod 8, 7 wraps to 0); go to SCAN if enable=1, else IDLE.
REQ-030 BUSY with timer==TIMEOUT-1 and xfer_done=0: pulse abort for one cycle, set timeout_err=1, advance rr_ptr as in REQ-029, and leave BUSY.
REQ-031 If xfer_done=1 and the timeout condition occur in the same cycle, done wins: no abort, no error.
REQ-032 The enable value is ignored in BUSY; the slot always completes or times out.
REQ-033 xfer_done or grant_ready outside the states that use them SHALL be ignored.
REQ-034 The earliest re-grant is 1 cycle after xfer_done (SCAN), with grant_valid 2 cycles after xfer_done.
REQ-035 err_clear=1 clears timeout_err; if a timeout sets it in the same cycle, set wins.
REQ-036 A grant with grant_len=0 is never issued.

Reset
REQ-037 While reset=0 (asynchronously): state=IDLE, rr_ptr=0, grant_valid=0, grant_port=0, grant_dir=0, grant_len=0, abort=0, timeout_err=0, busy=0, timer=0.
REQ-038 Reset asserted mid-slot abandons the slot; no abort pulse is issued. After release, scanning starts at port 0.

Verification
REQ-039 Fairness: all mask bits set, all pend=10; engine acks immediately and returns done 3 cycles later -> grants issued for ports 0,1,...,7,0 in order, each with len=10.
REQ-040 Burst cap and direction: port 5 pend=2000, others 0, MAX_BURST=64 -> grant_port=5, grant_dir=0, grant_len=64; port 2 pend=7 -> grant_dir=1, grant_len=7.
REQ-041 Mask and wrap: rr_ptr=7 after servicing port 6, mask=8'b0000_0001, pend[0]=1 -> next grant is port 0, reached via the 7->0 wrap.
REQ-042 Timeout: TIMEOUT=16, grant accepted, no done -> abort high exactly 16 cycles after acceptance, timeout_err=1, scan resumes at grant_port+1; done coinciding with cycle 16 -> no abort.
REQ-043 Withdraw: enable dropped during OFFER with grant_ready=0 -> grant_valid=0 next cycle, state IDLE, and the same port is re-offered after enable returns.
REQ-044 Async reset: reset pulsed low in BUSY between clock edges -> all outputs at reset values immediately; first grant after release comes from the lowest eligible port.
